main_fsm: RTL and testbench
===========================

Name: main_fsm

Overview:
- Multicycle control unit for the rv32im core.
- Sequences fetch, decode, execute, memory and writeback over the shared ALU, register file, memory port and mul/div unit.
- Drives ALUOp into alu_decoder and supplies all datapath mux selects and write enables.
- Owns the memory and mul/div valid/ready handshakes.

Parameters:
- ENABLE_MULDIV, 1: 1 = M-extension ops sequenced through the mul/div unit; 0 = those ops go to ILLEGAL.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- op  in  7  instruction opcode, from the instruction register
- funct7_bit0  in  1  instr[25]; set = M-extension op when op=OP
- mem_ready  in  1  memory transfer accepted or completed this cycle
- muldiv_ready  in  1  mul/div result valid this cycle
- mem_valid  out  1  memory request
- MemWrite  out  1  request is a store
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  latch instruction and OldPC
- PCUpdate  out  1  unconditional PC write
- Branch  out  1  datapath writes PC when the branch-taken flag is set
- RegWrite  out  1  register file write
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = const 4
- ResultSrc  out  2  00 = ALUOut, 01 = mem data, 10 = ALU result, 11 = mul/div result
- ALUOp  out  `ALU_OP_WIDTH  ALU operation class, to alu_decoder
- muldiv_valid  out  1  mul/div start/hold
- instr_retired  out  1  one-cycle pulse on the final state of each instruction
- illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Moore FSM; outputs decode from the state register. In FETCH, LOAD and STORE the ready-qualified strobes are additionally gated by mem_ready.
- Reset: state <= FETCH, illegal <= 0.
  - While reset=1, every output is forced to 0, ALUOp included.
  - Reset in any state, including mid-handshake, forces FETCH on the next edge.
- Memory handshake:
  - mem_valid rises in a state and holds, with MemWrite, AdrSrc and ALU selects stable, until mem_ready is seen.
  - mem_ready is ignored whenever mem_valid=0.
- Mul/div handshake: muldiv_valid follows the same hold-until-ready rule.
- All outputs not listed for a state are 0.

States, as (outputs) -> next:
- FETCH (mem_valid, AdrSrc=0; on mem_ready also IRWrite, PCUpdate, SrcA=00, SrcB=10, ALU_OP_ADD, ResultSrc=10) -> DECODE on mem_ready, else stay.
- DECODE (SrcA=01, SrcB=01, ALU_OP_ADD; branch/JAL target into ALUOut) -> dispatch on op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> MULDIV if funct7_bit0 && ENABLE_MULDIV; ILLEGAL if funct7_bit0 && !ENABLE_MULDIV; else EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 1100011 -> BRANCH
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - 0001111 or 1110011 -> FETCH (no-op, instr_retired=1 in DECODE)
  - any other op -> ILLEGAL
- MEMADR (SrcA=10, SrcB=01, ALU_OP_ADD) -> LOAD if op[5]=0, else STORE.
- LOAD (mem_valid, AdrSrc=1) -> MEMWB on mem_ready.
- MEMWB (ResultSrc=01, RegWrite, instr_retired) -> FETCH.
- STORE (mem_valid, MemWrite, AdrSrc=1; instr_retired on mem_ready) -> FETCH on mem_ready.
- EXECUTER (SrcA=10, SrcB=00, ALU_OP_ARITH_LOGIC) -> ALUWB.
- EXECUTEI (SrcA=10, SrcB=01, ALU_OP_ARITH_LOGIC) -> ALUWB.
- ALUWB (ResultSrc=00, RegWrite, instr_retired) -> FETCH.
- MULDIV (muldiv_valid, SrcA=10, SrcB=00) -> MULDIVWB on muldiv_ready.
- MULDIVWB (ResultSrc=11, RegWrite, instr_retired) -> FETCH.
- JALR (SrcA=10, SrcB=01, ALU_OP_ADD; datapath clears bit 0) -> JAL.
- JAL (SrcA=01, SrcB=10, ALU_OP_ADD, ResultSrc=00, PCUpdate) -> ALUWB.
- BRANCH (SrcA=10, SrcB=00, ALU_OP_BRANCH, ResultSrc=00, Branch, instr_retired) -> FETCH.
- LUI (SrcB=01, ALU_OP_LUI) -> ALUWB.
- AUIPC (SrcA=01, SrcB=01, ALU_OP_AUIPC) -> ALUWB.
- ILLEGAL: illegal <= 1; stays in ILLEGAL until reset; no memory or register activity.

Latency with zero-wait memory (mem_ready tied high), cycles per instruction:
- BRANCH 3
- R/I/LUI/AUIPC/JAL/STORE 4
- LOAD/JALR 5
- mul/div: 3 + cycles until muldiv_ready + 1.
Each memory wait cycle adds 1.

Decomposition:
- riscv_defines.vh receives:
  - opcode constants
  - state encodings and `STATE_WIDTH
  - ALUSrcA, ALUSrcB and ResultSrc encodings
  - existing `ALU_OP_* and `ALU_OP_WIDTH
- Single module; no sub-module warranted.

Test Plan:
- Reset held 3 cycles, then released, mem_ready=1 -> all outputs 0 during reset; cycle 1 after release FETCH with mem_valid=1, IRWrite=1, PCUpdate=1.
- add (op=0110011, funct7_bit0=0) with mem_ready=1 -> FETCH, DECODE, EXECUTER (ALUOp=ALU_OP_ARITH_LOGIC), ALUWB (RegWrite=1, instr_retired=1); total 4 cycles.
- lw with mem_ready low 2 cycles in LOAD -> mem_valid and AdrSrc=1 stable for 3 cycles; MEMWB asserts RegWrite with ResultSrc=01; total 7 cycles.
- mul (funct7_bit0=1) with muldiv_ready after 5 cycles -> muldiv_valid held 5 cycles, MULDIVWB asserts ResultSrc=11; with ENABLE_MULDIV=0 -> illegal=1, sticky.
- jalr -> JALR, JAL (PCUpdate=1), ALUWB (ResultSrc=00); beq -> BRANCH with Branch=1 and ALUOp=ALU_OP_BRANCH for 1 cycle, then FETCH.
- reset asserted in STORE while mem_ready=0 -> mem_valid=0 during the reset cycle; FETCH after release; no MemWrite pulse is seen together with mem_ready.

Source files
------------

// File: rtl/main_fsm_pkg.sv
// Shared encodings for the rv32im multicycle control unit: opcodes, FSM state
// codes, datapath mux selects and the ALU operation classes sent to alu_decoder.
package main_fsm_pkg;

  localparam int STATE_WIDTH  = 5;
  localparam int ALU_OP_WIDTH = 3;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [STATE_WIDTH-1:0] S_FETCH    = 5'd0;
  localparam logic [STATE_WIDTH-1:0] S_DECODE   = 5'd1;
  localparam logic [STATE_WIDTH-1:0] S_MEMADR   = 5'd2;
  localparam logic [STATE_WIDTH-1:0] S_LOAD     = 5'd3;
  localparam logic [STATE_WIDTH-1:0] S_MEMWB    = 5'd4;
  localparam logic [STATE_WIDTH-1:0] S_STORE    = 5'd5;
  localparam logic [STATE_WIDTH-1:0] S_EXECUTER = 5'd6;
  localparam logic [STATE_WIDTH-1:0] S_EXECUTEI = 5'd7;
  localparam logic [STATE_WIDTH-1:0] S_ALUWB    = 5'd8;
  localparam logic [STATE_WIDTH-1:0] S_MULDIV   = 5'd9;
  localparam logic [STATE_WIDTH-1:0] S_MULDIVWB = 5'd10;
  localparam logic [STATE_WIDTH-1:0] S_JALR     = 5'd11;
  localparam logic [STATE_WIDTH-1:0] S_JAL      = 5'd12;
  localparam logic [STATE_WIDTH-1:0] S_BRANCH   = 5'd13;
  localparam logic [STATE_WIDTH-1:0] S_LUI      = 5'd14;
  localparam logic [STATE_WIDTH-1:0] S_AUIPC    = 5'd15;
  localparam logic [STATE_WIDTH-1:0] S_ILLEGAL  = 5'd16;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_MULDIV    = 2'b11;

  // Zero is reserved for "no ALU operation" so idle states are distinguishable.
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD         = 3'b001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ARITH_LOGIC = 3'b010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_BRANCH      = 3'b011;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_LUI         = 3'b100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AUIPC       = 3'b101;

endpackage

// File: rtl/main_fsm.sv
// Multicycle Moore control FSM for the rv32im core; sequences fetch, decode,
// execute, memory and writeback and owns the memory and mul/div handshakes.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int unsigned ENABLE_MULDIV = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              op,
  input  logic                    funct7_bit0,
  input  logic                    mem_ready,
  input  logic                    muldiv_ready,
  output logic                    mem_valid,
  output logic                    MemWrite,
  output logic                    AdrSrc,
  output logic                    IRWrite,
  output logic                    PCUpdate,
  output logic                    Branch,
  output logic                    RegWrite,
  output logic [1:0]              ALUSrcA,
  output logic [1:0]              ALUSrcB,
  output logic [1:0]              ResultSrc,
  output logic [ALU_OP_WIDTH-1:0] ALUOp,
  output logic                    muldiv_valid,
  output logic                    instr_retired,
  output logic                    illegal
);

  logic [STATE_WIDTH-1:0] state;
  logic [STATE_WIDTH-1:0] next_state;
  logic                   illegal_q;

  // The sticky flag is set on the edge that enters ILLEGAL so it is visible
  // in the first ILLEGAL cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == S_ILLEGAL)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_OP: begin
            if (!funct7_bit0)            next_state = S_EXECUTER;
            else if (ENABLE_MULDIV != 0) next_state = S_MULDIV;
            else                         next_state = S_ILLEGAL;
          end
          OP_OPIMM:          next_state = S_EXECUTEI;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_LUI:            next_state = S_LUI;
          OP_AUIPC:          next_state = S_AUIPC;
          OP_FENCE, OP_SYSTEM: next_state = S_FETCH;
          default:           next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   next_state = op[5] ? S_STORE : S_LOAD;
      S_LOAD:     if (mem_ready) next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_STORE:    if (mem_ready) next_state = S_FETCH;
      S_EXECUTER: next_state = S_ALUWB;
      S_EXECUTEI: next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_MULDIV:   if (muldiv_ready) next_state = S_MULDIVWB;
      S_MULDIVWB: next_state = S_FETCH;
      S_JALR:     next_state = S_JAL;
      S_JAL:      next_state = S_ALUWB;
      S_BRANCH:   next_state = S_FETCH;
      S_LUI:      next_state = S_ALUWB;
      S_AUIPC:    next_state = S_ALUWB;
      S_ILLEGAL:  next_state = S_ILLEGAL;
      default:    next_state = S_FETCH;
    endcase
  end

  // Outputs decode from the state register; reset masks every output so the
  // datapath sees no strobes while the FSM is being forced back to FETCH.
  always_comb begin
    mem_valid     = 1'b0;
    MemWrite      = 1'b0;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    PCUpdate      = 1'b0;
    Branch        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    ResultSrc     = RES_ALUOUT;
    ALUOp         = '0;
    muldiv_valid  = 1'b0;
    instr_retired = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_valid = 1'b1;
          if (mem_ready) begin
            IRWrite   = 1'b1;
            PCUpdate  = 1'b1;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            ALUOp     = ALU_OP_ADD;
            ResultSrc = RES_ALURESULT;
          end
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_OP_ADD;
          if (op == OP_FENCE || op == OP_SYSTEM)
            instr_retired = 1'b1;
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_OP_ADD;
        end
        S_LOAD: begin
          mem_valid = 1'b1;
          AdrSrc    = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc     = RES_MEMDATA;
          RegWrite      = 1'b1;
          instr_retired = 1'b1;
        end
        S_STORE: begin
          mem_valid     = 1'b1;
          MemWrite      = 1'b1;
          AdrSrc        = 1'b1;
          instr_retired = mem_ready;
        end
        S_EXECUTER: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_RS2;
          ALUOp   = ALU_OP_ARITH_LOGIC;
        end
        S_EXECUTEI: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_OP_ARITH_LOGIC;
        end
        S_ALUWB, S_MULDIVWB: begin
          ResultSrc     = (state == S_MULDIVWB) ? RES_MULDIV : RES_ALUOUT;
          RegWrite      = 1'b1;
          instr_retired = 1'b1;
        end
        S_MULDIV: begin
          muldiv_valid = 1'b1;
          ALUSrcA      = SRCA_RS1;
          ALUSrcB      = SRCB_RS2;
        end
        S_JALR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_OP_ADD;
        end
        S_JAL: begin
          ALUSrcA   = SRCA_OLDPC;
          ALUSrcB   = SRCB_FOUR;
          ALUOp     = ALU_OP_ADD;
          ResultSrc = RES_ALUOUT;
          PCUpdate  = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA       = SRCA_RS1;
          ALUSrcB       = SRCB_RS2;
          ALUOp         = ALU_OP_BRANCH;
          ResultSrc     = RES_ALUOUT;
          Branch        = 1'b1;
          instr_retired = 1'b1;
        end
        S_LUI: begin
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_OP_LUI;
        end
        S_AUIPC: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_OP_AUIPC;
        end
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q && !reset;

endmodule

// File: tb/tb_main_fsm.sv
// Directed scoreboard bench for main_fsm: each stimulus cycle pushes its
// hand-derived output vector, and a negedge monitor pops and compares.
module tb_main_fsm;
  import main_fsm_pkg::*;

  typedef struct packed {
    logic       mv;
    logic       mw;
    logic       adr;
    logic       irw;
    logic       pcu;
    logic       br;
    logic       rw;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic [2:0] aop;
    logic       mdv;
    logic       ret;
    logic       ill;
  } out_t;

  typedef struct {
    out_t  main_v;
    out_t  nm_v;
    string name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic       funct7_bit0 = 1'b0;
  logic       mem_ready = 1'b1;
  logic       muldiv_ready = 1'b0;

  logic       mem_valid, MemWrite, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ALUOp;
  logic       muldiv_valid, instr_retired, illegal;

  logic       nm_mem_valid, nm_MemWrite, nm_AdrSrc, nm_IRWrite, nm_PCUpdate;
  logic       nm_Branch, nm_RegWrite;
  logic [1:0] nm_ALUSrcA, nm_ALUSrcB, nm_ResultSrc;
  logic [2:0] nm_ALUOp;
  logic       nm_muldiv_valid, nm_instr_retired, nm_illegal;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic nm_ill_exp = 1'b0;

  out_t ZERO, F_RDY, F_WAIT, DEC, DEC_RET, EXR, EXI, ALUWB, MEMADR, LOADV;
  out_t MEMWB, STORE_W, STORE_R, MULD, MULWB, JALRV, JALV, BRV, LUIV, AUIPCV, ILL;

  main_fsm #(.ENABLE_MULDIV(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct7_bit0(funct7_bit0),
    .mem_ready(mem_ready), .muldiv_ready(muldiv_ready),
    .mem_valid(mem_valid), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCUpdate(PCUpdate), .Branch(Branch),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUOp(ALUOp), .muldiv_valid(muldiv_valid),
    .instr_retired(instr_retired), .illegal(illegal)
  );

  main_fsm #(.ENABLE_MULDIV(0)) dut_nm (
    .clk(clk), .reset(reset), .op(op), .funct7_bit0(funct7_bit0),
    .mem_ready(mem_ready), .muldiv_ready(muldiv_ready),
    .mem_valid(nm_mem_valid), .MemWrite(nm_MemWrite), .AdrSrc(nm_AdrSrc),
    .IRWrite(nm_IRWrite), .PCUpdate(nm_PCUpdate), .Branch(nm_Branch),
    .RegWrite(nm_RegWrite), .ALUSrcA(nm_ALUSrcA), .ALUSrcB(nm_ALUSrcB),
    .ResultSrc(nm_ResultSrc), .ALUOp(nm_ALUOp), .muldiv_valid(nm_muldiv_valid),
    .instr_retired(nm_instr_retired), .illegal(nm_illegal)
  );

  always #5 clk = ~clk;

  function automatic out_t o(input logic mv, mw, adr, irw, pcu, br, rw,
                             input logic [1:0] sa, sb, rs, input logic [2:0] aop,
                             input logic mdv, ret, ill);
    return '{mv, mw, adr, irw, pcu, br, rw, sa, sb, rs, aop, mdv, ret, ill};
  endfunction

  // Drive one cycle of inputs just after the edge and queue what that cycle must show.
  task automatic applyStimulus(input logic rst, input logic [6:0] op_v, input logic f7,
                               input logic mr, input logic mdr, input out_t ev,
                               input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    op           = op_v;
    funct7_bit0  = f7;
    mem_ready    = mr;
    muldiv_ready = mdr;
    e.main_v = ev;
    e.nm_v   = nm_ill_exp ? ILL : ev;
    e.name   = name;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    out_t act, act_nm;
    act = '{mem_valid, MemWrite, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite,
            ALUSrcA, ALUSrcB, ResultSrc, ALUOp, muldiv_valid, instr_retired, illegal};
    act_nm = '{nm_mem_valid, nm_MemWrite, nm_AdrSrc, nm_IRWrite, nm_PCUpdate,
               nm_Branch, nm_RegWrite, nm_ALUSrcA, nm_ALUSrcB, nm_ResultSrc,
               nm_ALUOp, nm_muldiv_valid, nm_instr_retired, nm_illegal};
    checks++;
    if (act !== e.main_v || act_nm !== e.nm_v) begin
      failures++;
      $display("[TB] FAIL %s: got %b / nomul %b, expected %b / nomul %b",
               e.name, act, act_nm, e.main_v, e.nm_v);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    //          mv mw ad ir pc br rw sa     sb     rs     aop                 md rt il
    ZERO    = o(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000,             0, 0, 0);
    F_RDY   = o(1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b10, 2'b10, ALU_OP_ADD,         0, 0, 0);
    F_WAIT  = o(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000,             0, 0, 0);
    DEC     = o(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, ALU_OP_ADD,         0, 0, 0);
    DEC_RET = o(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, ALU_OP_ADD,         0, 1, 0);
    EXR     = o(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, ALU_OP_ARITH_LOGIC, 0, 0, 0);
    EXI     = o(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ALU_OP_ARITH_LOGIC, 0, 0, 0);
    ALUWB   = o(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000,             0, 1, 0);
    MEMADR  = o(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ALU_OP_ADD,         0, 0, 0);
    LOADV   = o(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000,             0, 0, 0);
    MEMWB   = o(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 3'b000,             0, 1, 0);
    STORE_W = o(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000,             0, 0, 0);
    STORE_R = o(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000,             0, 1, 0);
    MULD    = o(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000,             1, 0, 0);
    MULWB   = o(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b11, 3'b000,             0, 1, 0);
    JALRV   = o(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, ALU_OP_ADD,         0, 0, 0);
    JALV    = o(0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b10, 2'b00, ALU_OP_ADD,         0, 0, 0);
    BRV     = o(0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b00, ALU_OP_BRANCH,      0, 1, 0);
    LUIV    = o(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, ALU_OP_LUI,         0, 0, 0);
    AUIPCV  = o(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, ALU_OP_AUIPC,       0, 0, 0);
    ILL     = o(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000,             0, 0, 1);

    $display("[TB] reset held 3 cycles");
    repeat (3) applyStimulus(1, OP_OP, 0, 1, 0, ZERO, "reset");

    $display("[TB] add");
    applyStimulus(0, OP_OP, 0, 1, 0, F_RDY, "add_fetch");
    applyStimulus(0, OP_OP, 0, 1, 0, DEC,   "add_decode");
    applyStimulus(0, OP_OP, 0, 1, 1, EXR,   "add_execr");
    applyStimulus(0, OP_OP, 0, 1, 0, ALUWB, "add_aluwb");

    $display("[TB] addi");
    applyStimulus(0, OP_OPIMM, 0, 1, 0, F_RDY, "addi_fetch");
    applyStimulus(0, OP_OPIMM, 0, 1, 0, DEC,   "addi_decode");
    applyStimulus(0, OP_OPIMM, 0, 1, 0, EXI,   "addi_execi");
    applyStimulus(0, OP_OPIMM, 0, 1, 0, ALUWB, "addi_aluwb");

    $display("[TB] lw with two wait cycles");
    applyStimulus(0, OP_LOAD, 0, 1, 0, F_RDY,  "lw_fetch");
    applyStimulus(0, OP_LOAD, 0, 1, 0, DEC,    "lw_decode");
    applyStimulus(0, OP_LOAD, 0, 1, 0, MEMADR, "lw_memadr");
    applyStimulus(0, OP_LOAD, 0, 0, 0, LOADV,  "lw_load_wait1");
    applyStimulus(0, OP_LOAD, 0, 0, 0, LOADV,  "lw_load_wait2");
    applyStimulus(0, OP_LOAD, 0, 1, 0, LOADV,  "lw_load_done");
    applyStimulus(0, OP_LOAD, 0, 1, 0, MEMWB,  "lw_memwb");

    $display("[TB] lui with one fetch wait");
    applyStimulus(0, OP_LUI, 0, 0, 0, F_WAIT, "lui_fetch_wait");
    applyStimulus(0, OP_LUI, 0, 1, 0, F_RDY,  "lui_fetch");
    applyStimulus(0, OP_LUI, 0, 1, 0, DEC,    "lui_decode");
    applyStimulus(0, OP_LUI, 0, 1, 0, LUIV,   "lui_lui");
    applyStimulus(0, OP_LUI, 0, 1, 0, ALUWB,  "lui_aluwb");

    $display("[TB] fence and auipc");
    applyStimulus(0, OP_FENCE, 0, 1, 0, F_RDY,   "fence_fetch");
    applyStimulus(0, OP_FENCE, 0, 1, 0, DEC_RET, "fence_decode");
    applyStimulus(0, OP_AUIPC, 0, 1, 0, F_RDY,   "auipc_fetch");
    applyStimulus(0, OP_AUIPC, 0, 1, 0, DEC,     "auipc_decode");
    applyStimulus(0, OP_AUIPC, 0, 1, 0, AUIPCV,  "auipc_auipc");
    applyStimulus(0, OP_AUIPC, 0, 1, 0, ALUWB,   "auipc_aluwb");

    $display("[TB] jalr and beq");
    applyStimulus(0, OP_JALR, 0, 1, 0, F_RDY,   "jalr_fetch");
    applyStimulus(0, OP_JALR, 0, 1, 0, DEC,     "jalr_decode");
    applyStimulus(0, OP_JALR, 0, 1, 0, JALRV,   "jalr_jalr");
    applyStimulus(0, OP_JALR, 0, 1, 0, JALV,    "jalr_jal");
    applyStimulus(0, OP_JALR, 0, 1, 0, ALUWB,   "jalr_aluwb");
    applyStimulus(0, OP_BRANCH, 0, 1, 0, F_RDY, "beq_fetch");
    applyStimulus(0, OP_BRANCH, 0, 1, 0, DEC,   "beq_decode");
    applyStimulus(0, OP_BRANCH, 0, 1, 0, BRV,   "beq_branch");

    $display("[TB] sw zero wait");
    applyStimulus(0, OP_STORE, 0, 1, 0, F_RDY,   "sw_fetch");
    applyStimulus(0, OP_STORE, 0, 1, 0, DEC,     "sw_decode");
    applyStimulus(0, OP_STORE, 0, 1, 0, MEMADR,  "sw_memadr");
    applyStimulus(0, OP_STORE, 0, 1, 0, STORE_R, "sw_store");

    $display("[TB] mul with result after 5 cycles");
    applyStimulus(0, OP_OP, 1, 1, 0, F_RDY, "mul_fetch");
    applyStimulus(0, OP_OP, 1, 1, 0, DEC,   "mul_decode");
    nm_ill_exp = 1'b1;
    repeat (4) applyStimulus(0, OP_OP, 1, 1, 0, MULD, "mul_hold");
    applyStimulus(0, OP_OP, 1, 1, 1, MULD,  "mul_done");
    applyStimulus(0, OP_OP, 1, 1, 0, MULWB, "mul_muldivwb");

    $display("[TB] reset during a stalled store");
    applyStimulus(0, OP_STORE, 0, 1, 0, F_RDY,   "rsw_fetch");
    applyStimulus(0, OP_STORE, 0, 1, 0, DEC,     "rsw_decode");
    applyStimulus(0, OP_STORE, 0, 1, 0, MEMADR,  "rsw_memadr");
    applyStimulus(0, OP_STORE, 0, 0, 0, STORE_W, "rsw_store_wait");
    nm_ill_exp = 1'b0;
    applyStimulus(1, OP_STORE, 0, 0, 0, ZERO,    "rsw_reset");
    applyStimulus(1, OP_STORE, 0, 1, 0, ZERO,    "rsw_reset_ready");
    applyStimulus(0, OP_STORE, 0, 1, 0, F_RDY,   "rsw_refetch");

    $display("[TB] unknown opcode goes sticky illegal");
    applyStimulus(0, 7'b1111111, 0, 1, 0, DEC, "ill_decode");
    nm_ill_exp = 1'b1;
    repeat (3) applyStimulus(0, 7'b1111111, 0, 1, 1, ILL, "ill_sticky");
    applyStimulus(0, OP_OP, 0, 1, 0, ILL, "ill_ignores_op");

    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
